// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the MEM-stage data-memory responder: funct3 codes, FSM states,
// and small helpers for access size and alignment.
package dmem_responder_pkg;

  localparam int XLEN = 64;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Access width in bytes: 1, 2, 4 or 8, taken from the low two funct3 bits.
  function automatic logic [3:0] acc_bytes(input logic [2:0] funct3);
    return 4'd1 << funct3[1:0];
  endfunction

  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [2:0] addr_lo);
    logic [2:0] w_mask;
    w_mask = 3'(acc_bytes(funct3) - 4'd1);
    return (addr_lo & w_mask) != 3'b000;
  endfunction

endpackage

// File: rtl/dmem_load_extend.sv
// Combinational load formatter: sign/zero-extends the low bytes of a raw little-endian
// word according to RV64 load funct3; flags funct3=111 as illegal.
module dmem_load_extend
  import dmem_responder_pkg::*;
(
  input  logic [XLEN-1:0] i_raw,
  input  logic [2:0]      i_funct3,
  output logic [XLEN-1:0] o_data,
  output logic            o_illegal
);

  always_comb begin
    o_data    = '0;
    o_illegal = 1'b0;
    case (i_funct3)
      F3_B:    o_data = {{56{i_raw[7]}},  i_raw[7:0]};
      F3_H:    o_data = {{48{i_raw[15]}}, i_raw[15:0]};
      F3_W:    o_data = {{32{i_raw[31]}}, i_raw[31:0]};
      F3_D:    o_data = i_raw;
      F3_BU:   o_data = {56'd0, i_raw[7:0]};
      F3_HU:   o_data = {48'd0, i_raw[15:0]};
      F3_WU:   o_data = {32'd0, i_raw[31:0]};
      default: o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data memory responder: IDLE/WAIT/RESP FSM with programmable latency, byte-wise
// little-endian access wrapping modulo DEPTH. Optional macro DMEM_MISALIGN_TRAP_EN traps misaligned accesses.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_write,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_err,
  output logic            busy
);

  localparam int AW = $clog2(DEPTH);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [3:0]        r_cnt;
  logic              r_write;
  logic [2:0]        r_funct3;
  logic [AW-1:0]     r_addr;
  logic [XLEN-1:0]   r_wdata;
  logic [XLEN-1:0]   r_rdata;
  logic              r_err;
  logic [7:0]        r_mem [DEPTH];

  logic [AW-1:0]     w_idx [8];
  logic [XLEN-1:0]   w_raw;
  logic [XLEN-1:0]   w_ld_data;
  logic              w_ld_illegal;
  logic              w_err;
  logic [XLEN-1:0]   w_rdata;
  logic              w_access;
  logic [3:0]        w_nbytes;
  logic              w_unused_addr;

  assign w_unused_addr = ^req_addr[XLEN-1:AW];

  // Each byte lane addresses its own index so multi-byte accesses wrap past DEPTH-1 to 0.
  for (genvar g = 0; g < 8; g++) begin : g_lane
    assign w_idx[g]       = r_addr + AW'(g);
    assign w_raw[8*g +: 8] = r_mem[w_idx[g]];
  end

  dmem_load_extend u_load_extend (
    .i_raw     (w_raw),
    .i_funct3  (r_funct3),
    .o_data    (w_ld_data),
    .o_illegal (w_ld_illegal)
  );

`ifdef DMEM_MISALIGN_TRAP_EN
  assign w_err = (r_write ? r_funct3[2] : w_ld_illegal) | is_misaligned(r_funct3, r_addr[2:0]);
`else
  assign w_err = r_write ? r_funct3[2] : w_ld_illegal;
`endif

  assign w_rdata  = (r_write || w_err) ? '0 : w_ld_data;
  assign w_access = (r_state == ST_WAIT) && (r_cnt == 4'd0);
  assign w_nbytes = acc_bytes(r_funct3);

  assign req_ready  = (r_state == ST_IDLE);
  assign busy       = (r_state != ST_IDLE);
  assign resp_valid = (r_state == ST_RESP);
  assign resp_rdata = r_rdata;
  assign resp_err   = r_err;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (req_valid) w_state_nxt = ST_WAIT;
      ST_WAIT: if (r_cnt == 4'd0) w_state_nxt = ST_RESP;
      ST_RESP: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt    <= '0;
      r_write  <= 1'b0;
      r_funct3 <= '0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
    end else begin
      if (r_state == ST_IDLE && req_valid) begin
        r_cnt    <= 4'(LATENCY - 1);
        r_write  <= req_write;
        r_funct3 <= req_funct3;
        r_addr   <= req_addr[AW-1:0];
        r_wdata  <= req_wdata;
      end else if (r_state == ST_WAIT) begin
        if (r_cnt != 4'd0) begin
          r_cnt <= r_cnt - 4'd1;
        end else begin
          r_rdata <= w_rdata;
          r_err   <= w_err;
        end
      end
    end
  end

  // Storage is not reset; a reset forces IDLE, which blocks any pending write.
  always_ff @(posedge clk) begin
    if (w_access && r_write && !w_err) begin
      for (int i = 0; i < 8; i++) begin
        if (i < int'(w_nbytes)) r_mem[w_idx[i]] <= r_wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized scoreboard bench for dmem_responder against a byte-array reference model.
module tb_dmem_responder;

  localparam int DEPTH = 1024;
  localparam int LAT   = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [63:0] req_addr = 64'd0;
  logic [63:0] req_wdata = 64'd0;
  logic        resp_valid;
  logic [63:0] resp_rdata;
  logic        resp_err;
  logic        busy;

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] rdata;
    logic        err;
    int          due;
  } exp_t;
  exp_t exp_q[$];

  logic [7:0] mdl_mem [DEPTH];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, req);
    end
  endtask

  task automatic finish_now(input string why);
    fails++;
    $display("FAIL %s: timeout", why);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  endtask

  // Reference: straight from the access rules; also applies the store to the model memory.
  function automatic void model(input bit wr, input logic [2:0] f3, input logic [63:0] addr,
                                input logic [63:0] wd, output logic [63:0] rd, output logic err);
    int idx, size;
    logic [63:0] v;
    idx  = int'(addr % 64'(DEPTH));
    size = 1 << f3[1:0];
    err  = wr ? f3[2] : (f3 == 3'd7);
`ifdef DMEM_MISALIGN_TRAP_EN
    if (idx % size != 0) err = 1'b1;
`endif
    rd = 64'd0;
    if (!err) begin
      if (wr) begin
        for (int i = 0; i < size; i++) mdl_mem[(idx + i) % DEPTH] = wd[8*i +: 8];
      end else begin
        v = 64'd0;
        for (int i = 0; i < size; i++) v = v | (64'(mdl_mem[(idx + i) % DEPTH]) << (8 * i));
        if (!f3[2] && size < 8 && v[8*size-1]) v = v | (~64'd0 << (8 * size));
        rd = v;
      end
    end
  endfunction

  task automatic do_req(input bit wr, input logic [2:0] f3, input logic [63:0] addr,
                        input logic [63:0] wd);
    exp_t e;
    int   n;
    model(wr, f3, addr, wd, e.rdata, e.err);
    @(negedge clk);
    req_valid = 1'b1; req_write = wr; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    n = 0;
    while (!req_ready) begin
      @(negedge clk);
      if (++n > 50) finish_now("accept");
    end
    e.due = cyc + 1 + LAT;
    exp_q.push_back(e);
    n = 0;
    do begin
      @(negedge clk);
      if (++n > 50) finish_now("response");
    end while (!resp_valid);
    req_valid = 1'b0;
    repeat ($urandom_range(0, 2)) @(negedge clk);
  endtask

  // Monitor: pops and compares whenever the DUT presents a response.
  logic prev_rv = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (resp_valid && prev_rv) begin
        fails++;
        $display("FAIL resp_pulse: resp_valid high 2 cycles, expected 1");
      end
      if (resp_valid && !prev_rv) begin
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL spurious_resp: got resp_valid=1 expected no response");
        end else begin
          e = exp_q.pop_front();
          check("rdata", resp_rdata, e.rdata);
          check("err", 64'(resp_err), 64'(e.err));
          check("latency_cycle", 64'(cyc), 64'(e.due));
          check("busy_in_resp", 64'(busy), 64'd1);
          check("ready_in_resp", 64'(req_ready), 64'd0);
        end
      end
      prev_rv <= resp_valid;
    end else begin
      prev_rv <= 1'b0;
    end
  end

  // Busy must be high for every cycle between acceptance and response.
  always @(negedge clk) begin
    if (!reset && busy === req_ready) begin
      fails++;
      $display("FAIL busy_vs_ready: busy=%0b req_ready=%0b expected opposite", busy, req_ready);
    end
  end

  initial begin
    int n;
    for (int i = 0; i < DEPTH; i++) mdl_mem[i] = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_ready", 64'(req_ready), 64'd1);
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_rdata", resp_rdata, 64'd0);
    check("rst_err", 64'(resp_err), 64'd0);
    reset = 1'b0;

    // Storage is not reset, so clear it through the normal store path first.
    for (int a = 0; a < DEPTH; a += 8) do_req(1'b1, 3'd3, 64'(a), 64'd0);

    do_req(1'b0, 3'd3, 64'h20, 64'd0);

    // Reset while the store is still waiting: nothing may commit.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'd3;
    req_addr = 64'h20; req_wdata = 64'hDEADBEEF_CAFEF00D;
    n = 0;
    while (!req_ready) begin
      @(negedge clk);
      if (++n > 50) finish_now("accept_before_reset");
    end
    @(negedge clk);
    check("wait_busy", 64'(busy), 64'd1);
    reset = 1'b1; req_valid = 1'b0;
    #1;
    check("midrst_ready", 64'(req_ready), 64'd1);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_resp_valid", 64'(resp_valid), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    do_req(1'b0, 3'd3, 64'h20, 64'd0);

    do_req(1'b1, 3'd3, 64'h10, 64'h8877665544332211);
    do_req(1'b0, 3'd3, 64'h10, 64'd0);
    do_req(1'b0, 3'd0, 64'h17, 64'd0);
    do_req(1'b0, 3'd4, 64'h17, 64'd0);
    do_req(1'b0, 3'd1, 64'h16, 64'd0);
    do_req(1'b0, 3'd6, 64'h14, 64'd0);
    do_req(1'b1, 3'd0, 64'h10, 64'hAB);
    do_req(1'b0, 3'd3, 64'h10, 64'd0);
    do_req(1'b0, 3'd7, 64'h10, 64'd0);
    do_req(1'b1, 3'd4, 64'h10, 64'hFFFF_FFFF_FFFF_FFFF);
    do_req(1'b0, 3'd3, 64'h10, 64'd0);
    do_req(1'b1, 3'd3, 64'h3FC, 64'h0807060504030201);
    do_req(1'b0, 3'd3, 64'h0, 64'd0);
    do_req(1'b1, 3'd3, 64'hFFFF_0000_0000_0410, 64'h1122334455667788);
    do_req(1'b0, 3'd3, 64'h10, 64'd0);

    for (int t = 0; t < 400; t++) begin
      logic [63:0] a;
      a = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) a[9:0] = 10'h3F8 + 10'($urandom_range(0, 7));
      else if ($urandom_range(0, 1) == 0) a[9:6] = 4'h0;
      do_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, {$urandom, $urandom});
    end

    n = 0;
    while (exp_q.size() != 0) begin
      @(negedge clk);
      if (++n > 50) finish_now("drain");
    end
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
